step_pulse_shaper: RTL and testbench

Sits directly downstream of the DDA step generator, between its internal step/dir signals and the STEPOUTPUT/DIROUTPUT pins. Each rising edge of the DDA step level becomes exactly one step pulse with programmable high and low widths. A programmable direction setup time is inserted before any pulse whose direction differs from the previous one. Bursts are buffered in a small direction FIFO, and a signed step position counter is kept for readback over SPI.

---
 rtl/step_pulse_shaper.sv | 211 +++++++++++++++++++++
 tb/tb_step_pulse_shaper.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_shaper.sv
// step_pulse_shaper
//
// Sits between the DDA step generator and the STEPOUTPUT/DIROUTPUT pins.
// Each rising edge of the DDA step level is queued in a small direction
// FIFO. The FIFO is then replayed as step pulses with programmable high
// and low widths. A programmable setup time is inserted before any pulse
// whose direction differs from the previous one. A signed position counter
// tracks every emitted step.
//
// Ports
//   CLK                system clock
//   resetn             synchronous, active-low reset
//   step_req           DDA step level; each 0->1 transition is one request
//   dir_in             direction of the request, sampled with the edge
//   enable             low: no new pulse is started (FIFO retained)
//   config_pulse_high  step_out high time in CLK cycles (0 behaves as 1)
//   config_pulse_low   minimum step_out low time in CLK cycles (0 as 1)
//   config_dir_setup   dir_out-to-step_out setup in CLK cycles (0 as 1)
//   clear_overflow     clears the sticky overflow flag
//   step_out           shaped step pulse
//   dir_out            registered direction
//   busy               FSM not idle or FIFO not empty
//   overflow           sticky: a step request was dropped on a full FIFO
//   position           two's-complement count of emitted steps
module step_pulse_shaper #(
    parameter int FIFO_BITS = 4,
    parameter int TIME_BITS = 16,
    parameter int POS_BITS  = 64
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic                 step_req,
    input  logic                 dir_in,
    input  logic                 enable,
    input  logic [TIME_BITS-1:0] config_pulse_high,
    input  logic [TIME_BITS-1:0] config_pulse_low,
    input  logic [TIME_BITS-1:0] config_dir_setup,
    input  logic                 clear_overflow,
    output logic                 step_out,
    output logic                 dir_out,
    output logic                 busy,
    output logic                 overflow,
    output logic [POS_BITS-1:0]  position
);

    localparam int DEPTH = 1 << FIFO_BITS;

    localparam logic [TIME_BITS-1:0] CNT_ONE = TIME_BITS'(1);
    localparam logic [FIFO_BITS:0]   PTR_ONE = (FIFO_BITS + 1)'(1);
    localparam logic [POS_BITS-1:0]  POS_ONE = POS_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW
    } state_e;

    state_e               state_q, state_d;
    logic [TIME_BITS-1:0] cnt_q, cnt_d;
    logic                 step_out_q, step_out_d;
    logic                 dir_out_q, dir_out_d;
    logic                 overflow_q, overflow_d;
    logic [POS_BITS-1:0]  position_q, position_d;
    logic                 step_req_q, step_req_d;
    logic [FIFO_BITS:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_BITS:0]   rd_ptr_q, rd_ptr_d;
    logic                 fifo_mem_q [DEPTH];

    logic req_edge;
    logic fifo_empty;
    logic fifo_full;
    logic fifo_head;
    logic pop;
    logic push;
    logic drop;
    logic start_pulse;

    // A state lasts max(n,1) cycles: the counter is loaded with n-1 on entry
    // and the state exits in the cycle it reads zero.
    function automatic logic [TIME_BITS-1:0] load_count(input logic [TIME_BITS-1:0] n);
        return (n == '0) ? '0 : n - CNT_ONE;
    endfunction

    // ---------------------------------------------------------------
    // Edge detect and FIFO control
    // ---------------------------------------------------------------
    always_comb begin
        step_req_d = step_req;
        req_edge   = step_req & ~step_req_q;

        // The extra pointer MSB separates full from empty when the
        // index bits match.
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                     (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
        fifo_head  = fifo_mem_q[rd_ptr_q[FIFO_BITS-1:0]];

        pop  = (state_q == S_IDLE) && !fifo_empty && enable;
        // A pop in the same cycle frees the slot, so a full FIFO still
        // accepts the push.
        push = req_edge && (!fifo_full || pop);
        drop = req_edge && fifo_full && !pop;

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        // A drop outranks a clear arriving in the same cycle.
        overflow_d = overflow_q;
        if (clear_overflow) overflow_d = 1'b0;
        if (drop)           overflow_d = 1'b1;
    end

    // ---------------------------------------------------------------
    // Pulse FSM: next state and outputs
    // ---------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_out_d  = step_out_q;
        dir_out_d   = dir_out_q;
        position_d  = position_q;
        start_pulse = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (fifo_head != dir_out_q) begin
                        dir_out_d = fifo_head;
                        state_d   = S_SETUP;
                        cnt_d     = load_count(config_dir_setup);
                    end else begin
                        start_pulse = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) start_pulse = 1'b1;
                else             cnt_d = cnt_q - CNT_ONE;
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    step_out_d = 1'b0;
                    state_d    = S_LOW;
                    cnt_d      = load_count(config_pulse_low);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_LOW: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d = cnt_q - CNT_ONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Pulse start is shared by the same-direction IDLE pop and the end
        // of SETUP; the position counts with the direction now being driven.
        if (start_pulse) begin
            step_out_d = 1'b1;
            state_d    = S_HIGH;
            cnt_d      = load_count(config_pulse_high);
            position_d = dir_out_d ? position_q + POS_ONE : position_q - POS_ONE;
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            step_out_q <= 1'b0;
            dir_out_q  <= 1'b0;
            overflow_q <= 1'b0;
            position_q <= '0;
            // Starts high so a level already asserted at release is ignored.
            step_req_q <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_out_q <= step_out_d;
            dir_out_q  <= dir_out_d;
            overflow_q <= overflow_d;
            position_q <= position_d;
            step_req_q <= step_req_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // NOTE: the FIFO storage has no reset; resetting the pointers empties
    // it, and stale entries are never read before being rewritten.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= dir_in;
    end

    assign step_out = step_out_q;
    assign dir_out  = dir_out_q;
    assign overflow = overflow_q;
    assign position = position_q;
    assign busy     = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_step_pulse_shaper.sv
// tb_step_pulse_shaper
//
// Self-checking bench for step_pulse_shaper. A timeline model predicts,
// for each accepted step, the cycle window in which step_out is high and
// the cycle the shaper becomes free again; it is compared against the DUT
// every cycle. Directed tables and sequences cover the fixed-latency,
// overflow, minimum-timing, enable and reset-mid-pulse cases.
module tb_step_pulse_shaper;

    logic        CLK;
    logic        resetn;
    logic        step_req;
    logic        dir_in;
    logic        enable;
    logic [15:0] config_pulse_high;
    logic [15:0] config_pulse_low;
    logic [15:0] config_dir_setup;
    logic        clear_overflow;
    logic        step_out;
    logic        dir_out;
    logic        busy;
    logic        overflow;
    logic [63:0] position;

    step_pulse_shaper #(
        .FIFO_BITS(4),
        .TIME_BITS(16),
        .POS_BITS (64)
    ) dut (
        .CLK              (CLK),
        .resetn           (resetn),
        .step_req         (step_req),
        .dir_in           (dir_in),
        .enable           (enable),
        .config_pulse_high(config_pulse_high),
        .config_pulse_low (config_pulse_low),
        .config_dir_setup (config_dir_setup),
        .clear_overflow   (clear_overflow),
        .step_out         (step_out),
        .dir_out          (dir_out),
        .busy             (busy),
        .overflow         (overflow),
        .position         (position)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    longint rises[$];
    logic   prev_so  = 1'b0;

    // ---------------- reference model (timeline based) ----------------
    bit          mvalid = 0;
    bit          mq[$];
    longint      free_at, hi_start, hi_end, pend_cycle;
    bit          pend;
    logic [63:0] pend_delta;
    logic        m_dir, m_ovf, m_prev;
    logic [63:0] m_pos;

    function automatic longint dur(input logic [15:0] n);
        return (n == 16'd0) ? 64'sd1 : longint'(n);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Advance the model over the current cycle using the inputs now applied.
    task automatic model_step();
        bit     head;
        bit     drop;
        longint s;
        longint c;
        c    = cyc;
        drop = 0;
        if (!resetn) begin
            mq.delete();
            free_at  = 0;
            hi_start = -10;
            hi_end   = -11;
            pend     = 0;
            m_dir    = 1'b0;
            m_ovf    = 1'b0;
            m_pos    = 64'd0;
            m_prev   = 1'b1;
            mvalid   = 1;
            return;
        end
        if (!mvalid) return;
        if (c >= free_at && mq.size() > 0 && enable) begin
            head       = mq.pop_front();
            s          = (head != m_dir) ? dur(config_dir_setup) : 0;
            m_dir      = head;
            hi_start   = c + 1 + s;
            hi_end     = hi_start + dur(config_pulse_high) - 1;
            free_at    = hi_end + 1 + dur(config_pulse_low);
            pend       = 1;
            pend_cycle = hi_start;
            pend_delta = head ? 64'd1 : {64{1'b1}};
        end
        if (step_req && !m_prev) begin
            if (mq.size() < 16) mq.push_back(dir_in);
            else                drop = 1;
        end
        m_prev = step_req;
        if (drop)                m_ovf = 1'b1;
        else if (clear_overflow) m_ovf = 1'b0;
        if (pend && pend_cycle == c + 1) begin
            m_pos = m_pos + pend_delta;
            pend  = 0;
        end
    endtask

    task automatic model_check();
        check("model step_out", step_out, (cyc >= hi_start && cyc <= hi_end));
        check("model dir_out", dir_out, m_dir);
        check("model busy", busy, (cyc < free_at) || (mq.size() != 0));
        check("model overflow", overflow, m_ovf);
        check("model position", position, m_pos);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic rq, input logic dr, input logic en, input logic clr);
        step_req       = rq;
        dir_in         = dr;
        enable         = en;
        clear_overflow = clr;
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        cyc++;
        if (mvalid) model_check();
        if (step_out === 1'b1 && prev_so !== 1'b1) rises.push_back(cyc);
        prev_so = step_out;
    endtask

    task automatic do_reset(input int n, input logic rq);
        resetn = 1'b0;
        drive(rq, 1'b0, 1'b1, 1'b0);
        repeat (n) tick();
        resetn = 1'b1;
    endtask

    task automatic set_cfg(input int h, input int l, input int s);
        config_pulse_high = 16'(h);
        config_pulse_low  = 16'(l);
        config_dir_setup  = 16'(s);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        check({name, " drained"}, busy, 1'b0);
    endtask

    task automatic check_period(input longint p, input string name);
        for (int i = 1; i < rises.size(); i++)
            check(name, rises[i] - rises[i-1], p);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst_n;
        logic        req;
        logic        dir;
        logic        exp_step;
        logic        exp_dir;
        logic        exp_busy;
        logic [63:0] exp_pos;
    } vec_t;

    vec_t vecs[$];

    task automatic add_rows(input int n, input logic rst_n, input logic req, input logic dir,
                            input logic es, input logic ed, input logic eb, input logic [63:0] ep);
        vec_t v;
        v = '{rst_n, req, dir, es, ed, eb, ep};
        repeat (n) vecs.push_back(v);
    endtask

    localparam logic [63:0] MINUS_ONE = {64{1'b1}};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        set_cfg(4, 4, 3);

        // Reset release with step_req already high: no step counted.
        do_reset(3, 1'b1);
        rises.delete();
        repeat (10) tick();
        check("held req pulses", 64'(rises.size()), 64'd0);
        check("held req position", position, 64'd0);
        check("held req busy", busy, 1'b0);

        // Single-step tables: dir 0 without setup, then dir 1 with setup.
        // Row k inputs are applied in cycle k; its outputs are those of cycle k.
        add_rows(1, 1, 1, 0, 0, 0, 0, 64'd0);
        add_rows(1, 1, 0, 0, 0, 0, 1, 64'd0);
        add_rows(4, 1, 0, 0, 1, 0, 1, MINUS_ONE);
        add_rows(4, 1, 0, 0, 0, 0, 1, MINUS_ONE);
        add_rows(1, 1, 0, 0, 0, 0, 0, MINUS_ONE);
        add_rows(1, 0, 0, 0, 0, 0, 0, MINUS_ONE);
        add_rows(1, 1, 0, 0, 0, 0, 0, 64'd0);
        add_rows(1, 1, 1, 1, 0, 0, 0, 64'd0);
        add_rows(1, 1, 0, 1, 0, 0, 1, 64'd0);
        add_rows(3, 1, 0, 1, 0, 1, 1, 64'd0);
        add_rows(4, 1, 0, 1, 1, 1, 1, 64'd1);
        add_rows(4, 1, 0, 1, 0, 1, 1, 64'd1);
        add_rows(1, 1, 0, 1, 0, 1, 0, 64'd1);

        do_reset(3, 1'b0);
        repeat (2) tick();
        foreach (vecs[i]) begin
            resetn = vecs[i].rst_n;
            drive(vecs[i].req, vecs[i].dir, 1'b1, 1'b0);
            check($sformatf("vec%0d step_out", i), step_out, vecs[i].exp_step);
            check($sformatf("vec%0d dir_out", i), dir_out, vecs[i].exp_dir);
            check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d position", i), position, vecs[i].exp_pos);
            tick();
        end
        resetn = 1'b1;

        // Burst faster than the shaper drains: overflow, fixed period.
        do_reset(2, 1'b0);
        tick();
        rises.delete();
        for (int i = 0; i < 80; i++) begin
            drive((i % 2) == 0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        wait_idle(2000, "burst");
        check("burst overflow", overflow, 1'b1);
        check("burst position", position, 64'(rises.size()));
        check("burst dropped some", 64'(rises.size() < 40), 64'd1);
        check_period(9, "burst period");
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check("overflow cleared", overflow, 1'b0);

        // Zero timing: 1 high / 1 low, period 3.
        set_cfg(0, 0, 0);
        do_reset(2, 1'b0);
        tick();
        rises.delete();
        for (int i = 0; i < 12; i++) begin
            drive((i % 2) == 0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        wait_idle(200, "zero timing");
        check("zero timing pulses", 64'(rises.size()), 64'd6);
        check_period(3, "zero timing period");

        // 1000 alternating-direction steps return to position 0.
        do_reset(2, 1'b0);
        tick();
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, (i % 2) == 0, 1'b1, 1'b0);
            tick();
            drive(1'b0, (i % 2) == 0, 1'b1, 1'b0);
            tick();
            wait_idle(20, "alternating");
        end
        check("alternating position", position, 64'd0);

        // enable low holds queued steps.
        set_cfg(4, 4, 3);
        do_reset(2, 1'b0);
        tick();
        rises.delete();
        for (int i = 0; i < 10; i++) begin
            drive((i % 2) == 0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        check("disabled pulses", 64'(rises.size()), 64'd0);
        check("disabled busy", busy, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle(200, "enabled");
        check("enabled pulses", 64'(rises.size()), 64'd5);
        check("enabled position", position, 64'hFFFF_FFFF_FFFF_FFFB);

        // Reset during the third HIGH of a second queued batch.
        rises.delete();
        for (int i = 0; i < 10; i++) begin
            drive((i % 2) == 0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 200 && rises.size() < 3; k++) tick();
        check("third pulse reached", 64'(rises.size()), 64'd3);
        check("third pulse high", step_out, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("reset mid-pulse step_out", step_out, 1'b0);
        check("reset mid-pulse busy", busy, 1'b0);
        check("reset mid-pulse position", position, 64'd0);
        repeat (30) tick();
        check("no pulses after reset", 64'(rises.size()), 64'd3);

        // Randomized bursts against the timeline model.
        for (int b = 0; b < 8; b++) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
            for (int i = 0; i < 500; i++) begin
                resetn = ($urandom_range(0, 399) != 0);
                drive(1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
                      ($urandom_range(0, 15) == 0));
                tick();
            end
            resetn = 1'b1;
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            wait_idle(2000, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
